// File: rtl/ssd_scan_mux.sv
// rtl/ssd_scan_mux.sv - prescaled, frame-coherent seven-segment digit scan controller
// Optional anti-ghost blanking at the start of each digit slot: define SSD_BLANK_EN.
module ssd_scan_mux #(
  parameter int DIGITS        = 4,
  parameter int CODE_W        = 5,
  parameter int PRESCALE      = 50000,
  parameter int BLANK_CYCLES  = 8,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIGITS*CODE_W-1:0]    ssd_in,
  input  logic [DIGITS-1:0]           digit_en,
  output logic [DIGITS-1:0]           an,
  output logic [CODE_W-1:0]           code_out,
  output logic [$clog2(DIGITS)-1:0]   digit_idx,
  output logic                        frame_start
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DIGITS*CODE_W-1:0] snap_code_q, snap_code_d;
  logic [DIGITS-1:0]        snap_en_q, snap_en_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic                     frame_q, frame_d;
  logic                     tick;
  logic [DIGITS-1:0]        active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= CNT_LAST;
      idx_q       <= IDX_LAST;
      snap_code_q <= '0;
      snap_en_q   <= '0;
      an_q        <= AN_IDLE;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      snap_code_q <= snap_code_d;
      snap_en_q   <= snap_en_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  // Snapshot and index advance share the tick edge, so a new frame sees fresh inputs.
  always_comb begin
    tick        = (cnt_q == CNT_LAST);
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_d     = tick && (idx_d == '0);
    snap_code_d = frame_d ? ssd_in : snap_code_q;
    snap_en_d   = frame_d ? digit_en : snap_en_q;

    active = AN_IDLE;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IDX_W'(k) && snap_en_d[k]) begin
        active[DIGITS-1-k] = ~AN_IDLE[DIGITS-1-k];
      end
    end

    an_d = an_q;
`ifdef SSD_BLANK_EN
    if (tick) begin
      an_d = AN_IDLE;
    end else if (cnt_d == CNT_W'(BLANK_CYCLES)) begin
      an_d = active;
    end
`else
    if (tick) begin
      an_d = active;
    end
`endif
  end

  always_comb begin
    code_out = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        code_out = snap_code_q[(DIGITS-k)*CODE_W-1 -: CODE_W];
      end
    end
  end

  assign an          = an_q;
  assign digit_idx   = idx_q;
  assign frame_start = frame_q;

endmodule
